// File: rtl/rf_write_port_arbiter_pkg.sv
// mips_wb_pkg: shared widths, arbiter state and register-file write record
package mips_wb_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        NORMAL,
        FORCE
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;
endpackage

// File: rtl/rf_write_port_arbiter_if.sv
// rf_write_port_arbiter_if: WB stage, mul/div and register-file write port signals
interface rf_write_port_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    import mips_wb_pkg::*;

    logic                          pipe_wb_en;
    logic [REG_AW-1:0]             pipe_dest;
    logic [DATA_W-1:0]             pipe_value;
    logic                          md_valid;
    logic                          md_ready;
    logic [REG_AW-1:0]             md_dest;
    logic [DATA_W-1:0]             md_value;
    logic                          rf_we;
    logic [REG_AW-1:0]             rf_waddr;
    logic [DATA_W-1:0]             rf_wdata;
    logic                          stall_pipe;
    logic [$clog2(FIFO_DEPTH):0]   q_count;

    modport master (
        output pipe_wb_en, pipe_dest, pipe_value, md_valid, md_dest, md_value,
        input  md_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, q_count
    );

    modport slave (
        input  pipe_wb_en, pipe_dest, pipe_value, md_valid, md_dest, md_value,
        output md_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, q_count
    );
endinterface

// File: rtl/rf_write_port_arbiter_fifo.sv
// wb_result_fifo: small synchronous FIFO holding pending mul/div results
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    assign head = mem[rp];

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/rf_write_port_arbiter.sv
// rf_write_port_arbiter: shares the register-file write port between WB and mul/div results
module rf_write_port_arbiter
    import mips_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                    clk,
    input logic                    rst,
    rf_write_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t               state;
    logic [SW-1:0]            starve;
    logic [CW-1:0]            count;
    logic [REG_AW+DATA_W-1:0] head;
    logic                     pipe_ok;
    logic                     non_empty;
    logic                     push;
    logic                     pop;
    logic                     blocked;
    rf_wr_t                   wr;

    assign pipe_ok   = bus.pipe_wb_en && bus.pipe_dest != '0;
    assign non_empty = count != '0;
    assign pop       = non_empty && (state == FORCE || !pipe_ok);
    assign blocked   = state == NORMAL && non_empty && !pop;
    assign push      = bus.md_valid && bus.md_ready && bus.md_dest != '0;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REG_AW + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.md_dest, bus.md_value}),
        .head  (head),
        .count (count)
    );

    // Reset gates the combinational write path so the port is quiet asynchronously
    always_comb
        wr = !rst ? rf_wr_t'('0)
           : (state == NORMAL && pipe_ok) ? rf_wr_t'{we: 1'b1, addr: bus.pipe_dest, data: bus.pipe_value}
           : pop ? rf_wr_t'{we: 1'b1, addr: head[REG_AW+DATA_W-1:DATA_W], data: head[DATA_W-1:0]}
           : rf_wr_t'('0);

    assign bus.rf_we      = wr.we;
    assign bus.rf_waddr   = wr.addr;
    assign bus.rf_wdata   = wr.data;
    assign bus.md_ready   = rst && count < CW'(FIFO_DEPTH);
    assign bus.q_count    = count;
    assign bus.stall_pipe = state == FORCE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= NORMAL;
            starve <= '0;
        end else if (state == FORCE) begin
            state  <= NORMAL;
            starve <= '0;
        end else if (blocked) begin
            state  <= starve == SW'(STARVE_MAX - 1) ? FORCE : NORMAL;
            starve <= starve == SW'(STARVE_MAX - 1) ? '0 : starve + 1'b1;
        end else begin
            starve <= '0;
        end
    end
endmodule
